// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate tick, row/col counters, sync and
// visible-area flags (delayed to match the downstream RGB register), and
// registered line/frame start pulses.
module vga_sync_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_POL   = 0,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] row,
    output logic [10:0] col,
    output logic        pix_tick,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      col_q, col_d;
    logic [10:0]      row_q, row_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             tick;
    logic             col_wrap;
    logic             video_raw;
    logic             hsync_raw;
    logic             vsync_raw;

    // Divider, counters and start pulses: next-state logic.
    always_comb begin
        div_d         = div_q;
        col_d         = col_q;
        row_d         = row_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        tick     = (div_q == DIV_LAST);
        col_wrap = tick && (col_q == H_LAST);

        if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end

        if (tick) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 11'd1;
                end
            end else begin
                col_d = col_q + 11'd1;
            end
        end

        // Pulses are registered so they appear together with the wrapped counters.
        line_start_d  = col_wrap;
        frame_start_d = col_wrap && (row_q == V_LAST);
    end

    // Divider, counters and start pulses: state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Undelayed visible-area and sync levels decoded from the counters.
    always_comb begin
        video_raw = (col_q < H_VIS) && (row_q < V_VIS);
        hsync_raw = ((col_q >= HS_START) && (col_q <= HS_END)) ? SYNC_ON : SYNC_OFF;
        vsync_raw = ((row_q >= VS_START) && (row_q <= VS_END)) ? SYNC_ON : SYNC_OFF;
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign video_on = video_raw;
            assign hsync    = hsync_raw;
            assign vsync    = vsync_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] von_q, von_d;
            logic [SYNC_DELAY-1:0] hs_q, hs_d;
            logic [SYNC_DELAY-1:0] vs_q, vs_d;

            // Shift the raw levels one stage per clk; stage 0 takes the raw level.
            always_comb begin
                von_d    = von_q;
                hs_d     = hs_q;
                vs_d     = vs_q;
                von_d[0] = video_raw;
                hs_d[0]  = hsync_raw;
                vs_d[0]  = vsync_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    von_d[i] = von_q[i-1];
                    hs_d[i]  = hs_q[i-1];
                    vs_d[i]  = vs_q[i-1];
                end
            end

            // Delay-line registers; reset fills every stage with inactive levels.
            always_ff @(posedge clk) begin
                if (rst) begin
                    von_q <= '0;
                    hs_q  <= {SYNC_DELAY{SYNC_OFF}};
                    vs_q  <= {SYNC_DELAY{SYNC_OFF}};
                end else begin
                    von_q <= von_d;
                    hs_q  <= hs_d;
                    vs_q  <= vs_d;
                end
            end

            assign video_on = von_q[SYNC_DELAY-1];
            assign hsync    = hs_q[SYNC_DELAY-1];
            assign vsync    = vs_q[SYNC_DELAY-1];
        end
    endgenerate

    assign row         = row_q;
    assign col         = col_q;
    assign pix_tick    = tick;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA raster timing generator, directly upstream of the colour/pattern stage.
- Produces the pixel coordinates (row, col) the pattern stage consumes, a pixel-rate tick, and hsync, vsync and video_on.
- hsync, vsync and video_on are delayed to line up with the pattern stage's registered RGB outputs.
- Default timing is 640x480@60 from a 100 MHz system clock (25 MHz pixel rate).

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
CLK_DIV, 4, clk cycles per pixel (>=1)
SYNC_DELAY, 1, clk-cycle delay on hsync/vsync/video_on (0..7)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
row  output  11  current line counter, 0..V_TOTAL-1
col  output  11  current pixel counter, 0..H_TOTAL-1
pix_tick  output  1  one-clk pulse; counters advance on the next clk edge
video_on  output  1  visible-area flag, delayed by SYNC_DELAY
hsync  output  1  horizontal sync, delayed by SYNC_DELAY
vsync  output  1  vertical sync, delayed by SYNC_DELAY
line_start  output  1  one-clk pulse when col becomes 0
frame_start  output  1  one-clk pulse when (row,col) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- All logic is clocked on clk. rst is sampled only at a clk edge and overrides every other condition.

Pixel tick:
- Divider counter div runs 0..CLK_DIV-1 and wraps.
- pix_tick = (div == CLK_DIV-1), combinational from div.
- CLK_DIV=1: pix_tick is constantly 1 outside reset.

Counters:
- Both counters change only on an edge where pix_tick=1.
- col: increments, wrapping H_TOTAL-1 -> 0.
- row: increments only when col wraps; wraps V_TOTAL-1 -> 0.
- row and col are registers. They stay valid during blanking and hold steady for CLK_DIV clks.

Raw flags (combinational from the registered counters):
- video_on_raw = (col < H_VISIBLE) && (row < V_VISIBLE).
- hsync_raw asserted for col in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 at defaults).
- vsync_raw asserted for row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 at defaults).
- "Asserted" on a sync output means the line is driven to SYNC_POL; deasserted means ~SYNC_POL.

Delay line:
- Outputs = raw flags passed through a SYNC_DELAY-stage shift register clocked every clk.
- SYNC_DELAY=0 means the outputs are the raw flags directly.
- Default 1 matches the pattern stage's one-register RGB latency.

Pulses:
- line_start and frame_start are registered.
- Each is high for exactly one clk: the cycle in which the counters first show col=0 (line_start), or row=0 and col=0 (frame_start), following a wrap.
- No pulse is issued on reset release.
- frame_start always coincides with a line_start pulse.

Reset:
- div, row and col are 0; pix_tick follows div (1 only if CLK_DIV=1).
- video_on = 0; hsync = vsync = ~SYNC_POL.
- Every delay stage is loaded with inactive values.
- line_start = frame_start = 0.
- After release, the first pixel tick occurs CLK_DIV clks later (clk 1 when CLK_DIV=1).

Reset mid-frame:
- Counters return to (0,0) on the next edge, with no glitch pulses.
- Timing restarts cleanly; the first frame_start occurs one full frame later.

Test Plan:
- Reset then release, defaults -> row=col=0, hsync=vsync=1, video_on=0; pix_tick high on clk 3, 7, 11, ... after release; col=1 after the 4th clk.
- Run one full line -> col steps 0..799 then 0; row 0->1; line_start pulses once per 3200 clks; hsync low for exactly 384 clks, starting 1 clk after col reaches 656.
- Run one full frame -> vsync low while row is 490..491 (2 lines, 6400 clks); frame_start period 1,680,000 clks; video_on high 640x4 clks per line on rows 0..479 only.
- CLK_DIV=1, SYNC_DELAY=0 -> pix_tick constantly 1; col increments every clk; hsync asserted in the same cycle col=656.
- Assert rst for 1 clk at row=300, col=500 -> next cycle row=col=0, all outputs at reset values; no frame_start until 1,680,000 clks after release.
- SYNC_POL=1, SYNC_DELAY=3 -> syncs idle low and pulse high; hsync rises 3 clks after col first reads 656.
